// File: rtl/instruction_mem_banked.sv
// Banked instruction memory: run-time stream loader per bank and a registered 1-cycle fetch port.
// Optional INSTR_PARITY_EN adds one even-parity bit per stored word and a parity_err output.
module instruction_mem_banked #(
  parameter int unsigned     WIDTH    = 16,
  parameter int unsigned     DEPTH    = 128,
  parameter int unsigned     BANKS    = 4,
  parameter logic [WIDTH-1:0] NOP_WORD = 16'hBF00,
  parameter int unsigned     ADDR_W   = $clog2(DEPTH),
  parameter int unsigned     BANK_W   = $clog2(BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [WIDTH-1:0]  instr,
  output logic              instr_valid,
  output logic              bank_busy,
  input  logic              load_start,
  input  logic [BANK_W-1:0] load_bank,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  output logic              load_done,
`ifdef INSTR_PARITY_EN
  output logic              parity_err,
`endif
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                      state_q;
  logic [BANK_W-1:0]           cur_bank_q;
  logic [CntW-1:0]             wr_ptr_q;
  logic [CntW-1:0]             len_q [BANKS];
  logic [WIDTH-1:0]            mem_q [BANKS*DEPTH];

  logic                        wr_en;
  logic                        last_word;
  logic                        fetch_busy;
  logic                        fetch_in_range;
  logic [BANK_W+ADDR_W-1:0]    wr_idx;
  logic [BANK_W+ADDR_W-1:0]    rd_idx;

  assign wr_en          = (state_q == StLoad) && load_valid;
  assign wr_idx         = {cur_bank_q, wr_ptr_q[ADDR_W-1:0]};
  assign rd_idx         = {bank_sel, fetch_addr};
  // The DEPTH-th word always terminates the load, with or without load_last.
  assign last_word      = load_last || (wr_ptr_q == CntW'(DEPTH - 1));
  assign fetch_busy     = (state_q != StIdle) && (bank_sel == cur_bank_q);
  assign fetch_in_range = {1'b0, fetch_addr} < len_q[bank_sel];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= load_data;
    end
  end

`ifdef INSTR_PARITY_EN
  logic par_q [BANKS*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_q[wr_idx] <= ^load_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_bank_q <= '0;
      wr_ptr_q   <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      load_count <= '0;
      for (int b = 0; b < BANKS; b++) begin
        len_q[b] <= '0;
      end
    end else begin
      load_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            cur_bank_q       <= load_bank;
            wr_ptr_q         <= '0;
            len_q[load_bank] <= '0;
            load_ready       <= 1'b1;
            state_q          <= StLoad;
          end
        end
        StLoad: begin
          if (load_valid) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (last_word) begin
              state_q           <= StDone;
              load_ready        <= 1'b0;
              load_done         <= 1'b1;
              load_count        <= wr_ptr_q + 1'b1;
              len_q[cur_bank_q] <= wr_ptr_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      bank_busy   <= 1'b0;
`ifdef INSTR_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      instr_valid <= fetch_en;
      if (fetch_en) begin
        bank_busy <= fetch_busy;
        if (!fetch_busy && fetch_in_range) begin
          instr      <= mem_q[rd_idx];
`ifdef INSTR_PARITY_EN
          parity_err <= ^{par_q[rd_idx], mem_q[rd_idx]};
`endif
        end else begin
          instr      <= NOP_WORD;
`ifdef INSTR_PARITY_EN
          parity_err <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_mem_banked.sv
// Bench for instruction_mem_banked: directed tables and sequences plus random traffic checked
// against an array/counter model of bank images and loaded lengths.
module tb_instruction_mem_banked;

  localparam int D = 128;
  localparam int B = 4;
  localparam logic [15:0] NOP = 16'hBF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  bank_sel;
  logic        fetch_en;
  logic [6:0]  fetch_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        bank_busy;
  logic        load_start;
  logic [1:0]  load_bank;
  logic        load_valid;
  logic        load_last;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  load_count;
`ifdef INSTR_PARITY_EN
  logic        parity_err;
  logic        e_perr;
  bit          inj_on;
  int          inj_bank;
  int          inj_addr;
`endif

  always #5 clk = ~clk;

  instruction_mem_banked dut (
    .clk         (clk),
    .reset       (reset),
    .bank_sel    (bank_sel),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .bank_busy   (bank_busy),
    .load_start  (load_start),
    .load_bank   (load_bank),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
`ifdef INSTR_PARITY_EN
    .parity_err  (parity_err),
`endif
    .load_count  (load_count)
  );

  int checks = 0;
  int failures = 0;

  // Model: bank images, loaded lengths, and where the current load stands.
  logic [15:0] m_mem [B][D];
  int          m_len [B];
  int          ld_phase;  // 0 no load, 1 accepting words, 2 completion cycle
  int          ld_bank;
  int          ld_cnt;
  int          m_count;
  logic [15:0] e_instr;
  logic        e_valid;
  logic        e_busy;

  typedef struct {
    int          bank;
    int          addr;
    logic [15:0] exp;
  } vec_t;

  logic [15:0] fib [12] = '{16'h2000, 16'h4603, 16'h2101, 16'h2201, 16'h1889, 16'h4610,
                            16'h4619, 16'h3A01, 16'hD1FA, 16'h4770, 16'hE7FE, 16'hBF00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < B; b++) m_len[b] = 0;
    ld_phase = 0;
    ld_bank  = 0;
    ld_cnt   = 0;
    m_count  = 0;
    e_instr  = NOP;
    e_valid  = 1'b0;
    e_busy   = 1'b0;
`ifdef INSTR_PARITY_EN
    e_perr   = 1'b0;
`endif
  endtask

  task automatic idle_inputs();
    fetch_en   = 1'b0;
    bank_sel   = '0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_bank  = '0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
  endtask

  // One clock: predict from pre-edge inputs and model state, advance, compare #1 after the edge.
  task automatic tick();
    if (fetch_en) begin
`ifdef INSTR_PARITY_EN
      e_perr = 1'b0;
`endif
      if (ld_phase != 0 && int'(bank_sel) == ld_bank) begin
        e_instr = NOP;
        e_busy  = 1'b1;
      end else if (int'(fetch_addr) >= m_len[bank_sel]) begin
        e_instr = NOP;
        e_busy  = 1'b0;
      end else begin
        e_instr = m_mem[bank_sel][fetch_addr];
        e_busy  = 1'b0;
`ifdef INSTR_PARITY_EN
        e_perr  = inj_on && int'(bank_sel) == inj_bank && int'(fetch_addr) == inj_addr;
`endif
      end
    end
    e_valid = fetch_en;
    case (ld_phase)
      0: if (load_start) begin
        ld_phase = 1;
        ld_bank  = int'(load_bank);
        ld_cnt   = 0;
        m_len[ld_bank] = 0;
      end
      1: if (load_valid) begin
        m_mem[ld_bank][ld_cnt] = load_data;
`ifdef INSTR_PARITY_EN
        if (ld_bank == inj_bank && ld_cnt == inj_addr) inj_on = 1'b0;
`endif
        ld_cnt++;
        if (load_last || ld_cnt == D) begin
          ld_phase = 2;
          m_len[ld_bank] = ld_cnt;
          m_count = ld_cnt;
        end
      end
      default: ld_phase = 0;
    endcase
    @(posedge clk);
    #1;
    chk("instr_valid", instr_valid, e_valid);
    chk("instr", instr, e_instr);
    chk("bank_busy", bank_busy, e_busy);
    chk("load_ready", load_ready, ld_phase == 1);
    chk("load_done", load_done, ld_phase == 2);
    chk("load_count", load_count, m_count);
`ifdef INSTR_PARITY_EN
    chk("parity_err", parity_err, e_perr);
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    chk("rst_instr", instr, NOP);
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy", bank_busy, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_count", load_count, 0);
`ifdef INSTR_PARITY_EN
    chk("rst_perr", parity_err, 0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_vec(input vec_t v);
    fetch_en   = 1'b1;
    bank_sel   = 2'(v.bank);
    fetch_addr = 7'(v.addr);
    tick();
    chk($sformatf("vec_b%0d_a%0d", v.bank, v.addr), instr, v.exp);
    fetch_en = 1'b0;
  endtask

  task automatic load_prog(input int bank, input logic [15:0] words[$], input bit use_last);
    load_start = 1'b1;
    load_bank  = 2'(bank);
    tick();
    load_start = 1'b0;
    foreach (words[i]) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = use_last && (i == words.size() - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    vec_t        rst_vecs [4];
    vec_t        fib_vecs [15];
    logic [15:0] q [$];

    for (int i = 0; i < 4; i++) rst_vecs[i] = '{bank: 0, addr: i, exp: NOP};
    for (int i = 0; i < 12; i++) fib_vecs[i] = '{bank: 1, addr: i, exp: fib[i]};
    fib_vecs[12] = '{bank: 1, addr: 12, exp: NOP};
    fib_vecs[13] = '{bank: 1, addr: 127, exp: NOP};
    fib_vecs[14] = '{bank: 0, addr: 0, exp: NOP};
`ifdef INSTR_PARITY_EN
    inj_on   = 1'b0;
    inj_bank = 1;
    inj_addr = 4;
`endif

    do_reset();
    foreach (rst_vecs[i]) fetch_vec(rst_vecs[i]);

    // Fibonacci image into bank 1.
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(fib[i]);
    load_prog(1, q, 1'b1);
    chk("fib_done", load_done, 1);
    chk("fib_count", load_count, 12);
    tick();
    chk("fib_done_pulse", load_done, 0);
    foreach (fib_vecs[i]) fetch_vec(fib_vecs[i]);

    // Load bank 2 while fetching bank 1 every cycle.
    load_start = 1'b1;
    load_bank  = 2'd2;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_data  = 16'(16'h1000 + i);
      load_last  = (i == 7);
      fetch_en   = 1'b1;
      bank_sel   = 2'd1;
      fetch_addr = 7'(i);
      tick();
      chk("conc_word", instr, fib[i]);
      chk("conc_busy", bank_busy, 0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();

    // Fetching the bank under load returns a busy NOP.
    load_start = 1'b1;
    load_bank  = 2'd2;
    fetch_en   = 1'b0;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_en   = 1'b1;
      bank_sel   = 2'd2;
      fetch_addr = 7'(i);
      load_valid = 1'b1;
      load_data  = 16'(16'h2200 + i);
      load_last  = (i == 2);
      tick();
      chk("busy_nop", instr, NOP);
      chk("busy_flag", bank_busy, 1);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_en   = 1'b0;
    tick();
    tick();

    // 130 words without load_last: the load stops at DEPTH.
    q = {};
    for (int i = 0; i < 130; i++) q.push_back(16'($urandom));
    load_prog(3, q, 1'b0);
    chk("ovf_count", load_count, 128);
    chk("ovf_ready", load_ready, 0);
    fetch_vec('{bank: 3, addr: 127, exp: q[127]});
    fetch_vec('{bank: 3, addr: 0, exp: q[0]});

    // Reset in the middle of a bank 0 load.
    load_start = 1'b1;
    load_bank  = 2'd0;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 16'(16'h3300 + i);
      tick();
    end
    do_reset();
    for (int i = 0; i < 5; i++) fetch_vec('{bank: 0, addr: i, exp: NOP});

`ifdef INSTR_PARITY_EN
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(fib[i]);
    load_prog(1, q, 1'b1);
    tick();
    dut.mem_q[1*D + 4] = dut.mem_q[1*D + 4] ^ 16'h0010;
    m_mem[1][4] = m_mem[1][4] ^ 16'h0010;
    inj_on = 1'b1;
    for (int a = 3; a <= 5; a++) begin
      fetch_vec('{bank: 1, addr: a, exp: m_mem[1][a]});
      chk($sformatf("perr_a%0d", a), parity_err, a == 4);
    end
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      fetch_en   = ($urandom % 4) != 0;
      bank_sel   = 2'($urandom);
      fetch_addr = ($urandom % 4 == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
      load_start = ($urandom % 16) == 0;
      load_bank  = 2'($urandom);
      load_valid = ($urandom % 3) != 0;
      load_last  = ($urandom % 8) == 0;
      load_data  = 16'($urandom);
      tick();
    end

    idle_inputs();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
